// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake bundle between an issuing agent and alu_exec_ctrl.
// The issuer drives the instruction word and immediate with instr_valid.
// The controller answers with instr_ready, which is high only while idle.
interface alu_exec_ctrl_if #(
  parameter int WIDTH = 9
);
  logic             instr_valid;
  logic             instr_ready;
  logic [7:0]       instr;
  logic [WIDTH-1:0] imm;

  modport master (
    output instr_valid,
    output instr,
    output imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller placed upstream of the 9-bit ALU.
// Each instruction runs IDLE -> FETCH -> EXEC -> WB, one instruction per 4 cycles.
// The controller owns a small register file; the ALU itself sits outside and
// returns its combinational result on alu_out.
module alu_exec_ctrl #(
  parameter int WIDTH      = 9,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_exec_ctrl_if.slave        ibus,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [1:0]            alu_sel,
  input  logic [WIDTH-1:0]      alu_out,
  output logic [WIDTH-1:0]      result,
  output logic [REG_ADDR_W-1:0] result_rd,
  output logic                  done,
  output logic                  busy,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]      dbg_data
);

  localparam int NREG = 2 ** REG_ADDR_W;

  // Opcode encoding shares the ALU select encoding, except LDI which
  // bypasses the ALU and parks the select on ADD.
  localparam logic [1:0] OP_LDI  = 2'b11;
  localparam logic [1:0] SEL_ADD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      regs [NREG];

  // Instruction fields captured at the accepting edge
  logic [1:0]            op_p0;
  logic [REG_ADDR_W-1:0] rd_p0;
  logic [REG_ADDR_W-1:0] rs1_p0;
  logic [REG_ADDR_W-1:0] rs2_p0;
  logic [WIDTH-1:0]      imm_p0;

  // Handshake and status decode straight from the state register
  assign ibus.instr_ready = (state == S_IDLE);
  assign busy             = (state != S_IDLE);

  // Debug port reads the register file combinationally
  assign dbg_data = regs[dbg_addr];

  // Sequencer: accept, read operands, capture ALU result, write back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      regs      <= '{default: '0};
      op_p0     <= '0;
      rd_p0     <= '0;
      rs1_p0    <= '0;
      rs2_p0    <= '0;
      imm_p0    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      result    <= '0;
      result_rd <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Accept: latch the instruction word and immediate
        S_IDLE: begin
          if (ibus.instr_valid) begin
            op_p0  <= ibus.instr[7:6];
            rd_p0  <= REG_ADDR_W'(ibus.instr[5:4]);
            rs1_p0 <= REG_ADDR_W'(ibus.instr[3:2]);
            rs2_p0 <= REG_ADDR_W'(ibus.instr[1:0]);
            imm_p0 <= ibus.imm;
            state  <= S_FETCH;
          end
        end
        // Operand read: a write-back from the previous instruction has
        // already landed, so rd == rs needs no forwarding
        S_FETCH: begin
          alu_a   <= regs[rs1_p0];
          alu_b   <= regs[rs2_p0];
          alu_sel <= (op_p0 == OP_LDI) ? SEL_ADD : op_p0;
          state   <= S_EXEC;
        end
        // Execute: ALU inputs have been stable all cycle, capture its output
        S_EXEC: begin
          result    <= (op_p0 == OP_LDI) ? imm_p0 : alu_out;
          result_rd <= rd_p0;
          state     <= S_WB;
        end
        // Write-back: commit and pulse done for one cycle
        S_WB: begin
          regs[result_rd] <= result;
          done            <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural 9-bit ALU attached.
// Directed instructions push hand-computed expectations; a monitor pops one
// entry per done pulse and checks the result, ALU operands and register file.
module tb_alu_exec_ctrl;

  localparam int W  = 9;
  localparam int AW = 2;

  localparam logic [1:0] SUB  = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] MULT = 2'b10;
  localparam logic [1:0] LDI  = 2'b11;

  typedef struct {
    logic [1:0] rd;
    logic [8:0] res;
    logic [1:0] sel;
    logic       chk_ab;
    logic [8:0] a;
    logic [8:0] b;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  alu_a, alu_b, alu_out, result, dbg_data;
  logic [1:0]    alu_sel;
  logic [AW-1:0] result_rd, dbg_addr;
  logic          done, busy;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  alu_exec_ctrl_if #(.WIDTH(W)) ibus ();

  alu_exec_ctrl #(.WIDTH(W), .REG_ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ibus      (ibus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .result    (result),
    .result_rd (result_rd),
    .done      (done),
    .busy      (busy),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: SUB, ADD, MULT-by-3.5 approximation, all mod 2**9
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      2'b00:   alu_out = alu_a - alu_b;
      2'b01:   alu_out = alu_a + alu_b;
      2'b10:   alu_out = (alu_b << 1) + alu_b + (alu_b >> 1);
      default: alu_out = alu_a + alu_b;
    endcase
  end

  function automatic void chk(string name, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Offer one instruction, wait (bounded) for acceptance, optionally record
  // the expected write-back.
  task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic [8:0] imm_v, input logic push,
                       input logic [8:0] e_res, input logic chk_ab,
                       input logic [8:0] ea, input logic [8:0] eb);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!ibus.instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ibus.instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
      return;
    end
    ibus.instr_valid = 1'b1;
    ibus.instr       = {op, rd, rs1, rs2};
    ibus.imm         = imm_v;
    if (push) begin
      e.rd     = rd;
      e.res    = e_res;
      e.sel    = (op == LDI) ? ADD : op;
      e.chk_ab = chk_ab;
      e.a      = ea;
      e.b      = eb;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    ibus.instr_valid = 1'b0;
    ibus.instr       = 8'($urandom);
    ibus.imm         = 9'($urandom);
  endtask

  // Monitor: one scoreboard entry per done pulse
  initial begin
    exp_t e;
    logic prev_done;
    logic cur;
    prev_done = 1'b0;
    dbg_addr  = '0;
    forever begin
      @(negedge clk);
      cur = done;
      if (cur) begin
        chk("done_width", 16'(prev_done), 16'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done required=no_done");
        end else begin
          e = q.pop_front();
          chk("result", 16'(result), 16'(e.res));
          chk("result_rd", 16'(result_rd), 16'(e.rd));
          chk("alu_sel", 16'(alu_sel), 16'(e.sel));
          if (e.chk_ab) begin
            chk("alu_a", 16'(alu_a), 16'(e.a));
            chk("alu_b", 16'(alu_b), 16'(e.b));
          end
          dbg_addr = e.rd;
          #1;
          chk("dbg_reg", 16'(dbg_data), 16'(e.res));
        end
      end
      prev_done = cur;
    end
  end

  // Stimulus
  initial begin
    logic [7:0] s_instr [8];
    logic [8:0] s_imm   [8];
    logic [7:0] pat;
    int         n;

    rst_n            = 1'b1;
    ibus.instr_valid = 1'b0;
    ibus.instr       = '0;
    ibus.imm         = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    chk("rst_alu_b", 16'(alu_b), 16'd0);
    chk("rst_alu_sel", 16'(alu_sel), 16'd0);
    chk("rst_result", 16'(result), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ready", 16'(ibus.instr_ready), 16'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Immediate loads, then ADD/SUB/MULT on them
    issue(LDI, 2'd1, 2'd0, 2'd0, 9'd5, 1'b1, 9'd5, 1'b0, 9'd0, 9'd0);
    issue(LDI, 2'd2, 2'd0, 2'd0, 9'd3, 1'b1, 9'd3, 1'b0, 9'd0, 9'd0);
    issue(ADD, 2'd3, 2'd1, 2'd2, 9'd0, 1'b1, 9'd8, 1'b1, 9'd5, 9'd3);
    issue(SUB, 2'd0, 2'd2, 2'd1, 9'd0, 1'b1, 9'h1FE, 1'b1, 9'd3, 9'd5);
    issue(MULT, 2'd3, 2'd0, 2'd2, 9'd0, 1'b1, 9'd10, 1'b1, 9'h1FE, 9'd3);

    // Wrap-around and rd == rs
    issue(LDI, 2'd1, 2'd0, 2'd0, 9'h1FF, 1'b1, 9'h1FF, 1'b0, 9'd0, 9'd0);
    issue(LDI, 2'd2, 2'd0, 2'd0, 9'h001, 1'b1, 9'h001, 1'b0, 9'd0, 9'd0);
    issue(ADD, 2'd3, 2'd1, 2'd2, 9'd0, 1'b1, 9'h000, 1'b1, 9'h1FF, 9'h001);
    issue(ADD, 2'd1, 2'd1, 2'd1, 9'd0, 1'b1, 9'h1FE, 1'b1, 9'h1FF, 9'h1FF);
    issue(MULT, 2'd2, 2'd3, 2'd1, 9'd0, 1'b1, 9'h0F9, 1'b1, 9'h000, 9'h1FE);

    // Continuous offer: only slots 0 and 4 land while ready
    s_instr[0] = {LDI, 2'd0, 2'd0, 2'd0}; s_imm[0] = 9'h055;
    s_instr[1] = {LDI, 2'd1, 2'd0, 2'd0}; s_imm[1] = 9'h111;
    s_instr[2] = {LDI, 2'd1, 2'd0, 2'd0}; s_imm[2] = 9'h112;
    s_instr[3] = {LDI, 2'd1, 2'd0, 2'd0}; s_imm[3] = 9'h113;
    s_instr[4] = {ADD, 2'd2, 2'd0, 2'd0}; s_imm[4] = 9'h0EE;
    s_instr[5] = {LDI, 2'd3, 2'd0, 2'd0}; s_imm[5] = 9'h123;
    s_instr[6] = {LDI, 2'd3, 2'd0, 2'd0}; s_imm[6] = 9'h124;
    s_instr[7] = {LDI, 2'd3, 2'd0, 2'd0}; s_imm[7] = 9'h125;
    pat = 8'b0111_0111;
    n = 0;
    @(negedge clk);
    while (!ibus.instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stream_start_ready", 16'(ibus.instr_ready), 16'd1);
    q.push_back('{rd: 2'd0, res: 9'h055, sel: ADD, chk_ab: 1'b0, a: 9'd0, b: 9'd0});
    q.push_back('{rd: 2'd2, res: 9'h0AA, sel: ADD, chk_ab: 1'b1, a: 9'h055, b: 9'h055});
    ibus.instr_valid = 1'b1;
    ibus.instr       = s_instr[0];
    ibus.imm         = s_imm[0];
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk($sformatf("stream_busy_%0d", j), 16'(busy), 16'(pat[j]));
      if (j < 7) begin
        ibus.instr = s_instr[j+1];
        ibus.imm   = s_imm[j+1];
      end else begin
        ibus.instr_valid = 1'b0;
      end
    end

    // Ignored offers left R1 and R3 untouched
    issue(ADD, 2'd0, 2'd1, 2'd3, 9'd0, 1'b1, 9'h1FE, 1'b1, 9'h1FE, 9'h000);

    // Reset during EXEC aborts the instruction
    issue(ADD, 2'd2, 2'd0, 2'd1, 9'd0, 1'b0, 9'd0, 1'b0, 9'd0, 9'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_alu_a", 16'(alu_a), 16'd0);
    chk("abort_alu_b", 16'(alu_b), 16'd0);
    chk("abort_alu_sel", 16'(alu_sel), 16'd0);
    chk("abort_result", 16'(result), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", 16'(ibus.instr_ready), 16'd1);

    // Registers read back as zero after reset, then normal operation resumes
    issue(ADD, 2'd3, 2'd2, 2'd1, 9'd0, 1'b1, 9'h000, 1'b1, 9'h000, 9'h000);
    issue(LDI, 2'd2, 2'd0, 2'd0, 9'h0AB, 1'b1, 9'h0AB, 1'b0, 9'd0, 9'd0);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("sb_drained", 16'(q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
